// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate encodings, the ID/EX
// register layout and the small decode helpers used by decode_stage.
package riscv_pkg;
   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_AND   = 4'b0010,
      ALU_OR    = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SLT   = 4'b0101,
      ALU_SLL   = 4'b0110,
      ALU_SRL   = 4'b0111,
      ALU_SRA   = 4'b1000,
      ALU_SLTU  = 4'b1001,
      ALU_PASSB = 4'b1010
   } alu_op_t;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;

   typedef struct packed {
      logic            reg_write;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic            jalr;
      logic [1:0]      result_src;
      alu_op_t         alu_control;
      logic [2:0]      funct3;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            valid;
      logic            illegal;
   } idex_t;

   // alt is funct7[5]; it only matters for the add/sub and srl/sra slots.
   function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
      alu_op_t op;
      unique case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] ins, input imm_src_t src);
      logic [XLEN-1:0] imm;
      unique case (src)
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         default: imm = {{20{ins[31]}}, ins[31:20]};
      endcase
      return imm;
   endfunction
endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hard-wired to zero, same-cycle write-through to the read ports.
module regfile import riscv_pkg::*; (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      if (we && wa != 5'd0) regs_d[wa] = wd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass the write data so decode sees the value retiring this cycle.
   always_comb begin
      rd1 = regs_q[ra1];
      if (ra1 == 5'd0)                rd1 = '0;
      else if (we && wa == ra1)       rd1 = wd;
   end

   always_comb begin
      rd2 = regs_q[ra2];
      if (ra2 == 5'd0)                rd2 = '0;
      else if (we && wa == ra2)       rd2 = wd;
   end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate extension, register read and
// the ID/EX pipeline register with flush/stall hooks for the hazard unit.
module decode_stage import riscv_pkg::*; (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            ValidD,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallE,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic            JalrE,
   output logic [1:0]      ResultSrcE,
   output alu_op_t         ALUControlE,
   output logic [2:0]      Funct3E,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      RdE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic            ValidE,
   output logic            IllegalE
);
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [XLEN-1:0] rd1, rd2;
   logic            reg_write, mem_write, jump, branch, alu_src, jalr, known;
   logic [1:0]      result_src;
   alu_op_t         alu_control;
   imm_src_t        imm_src;
   idex_t           idex_d, idex_q;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7b5 = InstrD[30];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (Rs1D),
      .ra2 (Rs2D),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_comb begin
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      alu_src     = 1'b0;
      jalr        = 1'b0;
      result_src  = RES_ALU;
      alu_control = ALU_ADD;
      imm_src     = IMM_I;
      known       = 1'b1;
      unique case (opcode)
         OP_R: begin
            reg_write   = 1'b1;
            alu_control = alu_decode(funct3, funct7b5);
         end
         OP_IMM: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = alu_decode(funct3, funct7b5 && funct3 == 3'b101);
         end
         OP_LOAD: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = RES_MEM;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_src   = IMM_S;
         end
         OP_BRANCH: begin
            branch      = 1'b1;
            alu_control = ALU_SUB;
            imm_src     = IMM_B;
         end
         OP_JAL: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            result_src = RES_PC4;
            imm_src    = IMM_J;
         end
         OP_JALR: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            jalr       = 1'b1;
            alu_src    = 1'b1;
            result_src = RES_PC4;
         end
         OP_LUI: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_PASSB;
            imm_src     = IMM_U;
         end
         default: known = 1'b0;
      endcase
      // Bubbles and unknown opcodes must not disturb architectural state.
      if (!(ValidD && known)) begin
         reg_write   = 1'b0;
         mem_write   = 1'b0;
         jump        = 1'b0;
         branch      = 1'b0;
         alu_src     = 1'b0;
         jalr        = 1'b0;
         result_src  = RES_ALU;
         alu_control = ALU_ADD;
      end
   end

   always_comb begin
      idex_d = idex_q;
      if (FlushE) begin
         idex_d = '0;
      end else if (!StallE) begin
         idex_d.reg_write   = reg_write;
         idex_d.mem_write   = mem_write;
         idex_d.jump        = jump;
         idex_d.branch      = branch;
         idex_d.alu_src     = alu_src;
         idex_d.jalr        = jalr;
         idex_d.result_src  = result_src;
         idex_d.alu_control = alu_control;
         idex_d.funct3      = funct3;
         idex_d.rd1         = rd1;
         idex_d.rd2         = rd2;
         idex_d.imm_ext     = imm_extend(InstrD[31:7], imm_src);
         idex_d.pc          = PCD;
         idex_d.pc_plus4    = PCPlus4D;
         idex_d.rd          = InstrD[11:7];
         idex_d.rs1         = Rs1D;
         idex_d.rs2         = Rs2D;
         idex_d.valid       = ValidD;
         idex_d.illegal     = ValidD && !known;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) idex_q <= '0;
      else      idex_q <= idex_d;
   end

   assign RegWriteE   = idex_q.reg_write;
   assign MemWriteE   = idex_q.mem_write;
   assign JumpE       = idex_q.jump;
   assign BranchE     = idex_q.branch;
   assign ALUSrcE     = idex_q.alu_src;
   assign JalrE       = idex_q.jalr;
   assign ResultSrcE  = idex_q.result_src;
   assign ALUControlE = idex_q.alu_control;
   assign Funct3E     = idex_q.funct3;
   assign RD1E        = idex_q.rd1;
   assign RD2E        = idex_q.rd2;
   assign ImmExtE     = idex_q.imm_ext;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc_plus4;
   assign RdE         = idex_q.rd;
   assign Rs1E        = idex_q.rs1;
   assign Rs2E        = idex_q.rs2;
   assign ValidE      = idex_q.valid;
   assign IllegalE    = idex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed encodings plus randomized instruction streams
// checked against an instruction-level reference model with a register array.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
   logic        ValidD = 1'b0, RegWriteW = 1'b0, StallE = 1'b0, FlushE = 1'b0;
   logic [4:0]  RdW = '0;
   logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE, ValidE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]  rf_m [32];
   logic [191:0] exp_q, msk_q;
   logic [191:0] act;

   assign act = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE, ResultSrcE,
                 ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
                 RdE, Rs1E, Rs2E, ValidE, IllegalE};

   decode_stage dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .StallE(StallE), .FlushE(FlushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .JalrE(JalrE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
      .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E),
      .Rs2E(Rs2E), .ValidE(ValidE), .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rf_read(input logic [4:0] rs);
      if (rs == 5'd0) return 32'd0;
      if (RegWriteW && RdW == rs) return ResultW;
      return rf_m[rs];
   endfunction

   // Instruction-level expectation; m marks which bits the ISA pins down.
   function automatic void model(input logic [31:0] ins, input logic vld,
                                 input logic [31:0] pc, input logic [31:0] p4,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 output logic [191:0] e, output logic [191:0] m);
      logic [3:0]  tab [8];
      logic        rw, mw, jp, br, as, jr, known, ill, alt;
      logic        jp_c, as_c, alu_c, rs_c, imm_c;
      logic [1:0]  rsrc;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [31:0] imm;
      tab = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
      f3 = ins[14:12];
      alt = ins[30];
      {rw, mw, jp, br, as, jr} = '0;
      rsrc = 2'b00; alu = 4'd0; imm = '0; known = 1'b1;
      jp_c = 1'b1; as_c = 1'b1; alu_c = 1'b1; rs_c = 1'b1; imm_c = 1'b1;
      case (ins[6:0])
         7'b0110011: begin
            rw = 1; imm_c = 0;
            alu = (alt && f3 == 3'd0) ? 4'd1 : (alt && f3 == 3'd5) ? 4'd8 : tab[f3];
         end
         7'b0010011: begin
            rw = 1; as = 1; imm = 32'($signed(ins[31:20]));
            alu = (alt && f3 == 3'd5) ? 4'd8 : tab[f3];
         end
         7'b0000011: begin rw = 1; as = 1; rsrc = 2'b01; imm = 32'($signed(ins[31:20])); end
         7'b0100011: begin mw = 1; as = 1; imm = 32'($signed({ins[31:25], ins[11:7]})); end
         7'b1100011: begin
            br = 1; alu = 4'd1;
            imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         end
         7'b1101111: begin
            jp = 1; rw = 1; rsrc = 2'b10; as_c = 0; alu_c = 0;
            imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         7'b1100111: begin
            jr = 1; rw = 1; as = 1; rsrc = 2'b10; jp_c = 0; imm = 32'($signed(ins[31:20]));
         end
         7'b0110111: begin rw = 1; as = 1; alu = 4'd10; imm = ins & 32'hFFFF_F000; end
         default: known = 0;
      endcase
      if (!known || !vld) begin
         {rw, mw, jp, br, jr} = '0;
         jp_c = 1; as_c = 0; alu_c = 0; rs_c = 0; imm_c = 0;
      end
      ill = vld && !known;
      e = {rw, mw, jp, br, as, jr, rsrc, alu, f3, r1, r2, imm, pc, p4,
           ins[11:7], ins[19:15], ins[24:20], vld, ill};
      m = {1'b1, 1'b1, jp_c, 1'b1, as_c, 1'b1, {2{rs_c}}, {4{alu_c}}, {3{vld}},
           {64{vld}}, {32{imm_c && vld}}, {64{vld}}, {15{vld}}, 1'b1, 1'b1};
   endfunction

   task automatic tick();
      logic [191:0] e, m;
      model(InstrD, ValidD, PCD, PCPlus4D, rf_read(Rs1D), rf_read(Rs2D), e, m);
      @(posedge clk);
      if (FlushE) begin
         exp_q = '0; msk_q = '1;
      end else if (!StallE) begin
         exp_q = e; msk_q = m;
      end
      if (RegWriteW && RdW != 5'd0) rf_m[RdW] = ResultW;
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      exp_q = '0; msk_q = '1;
   endtask

   task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc);
      InstrD = ins; ValidD = 1'b1; PCD = pc; PCPlus4D = pc + 32'd4;
   endtask

   task automatic test_reset();
      model_reset();
      #3;
      vectors++;
      if (act !== 192'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected 0", act);
      end
      InstrD = 32'h0001_8233;
      #1;
      vectors++;
      if ({Rs1D, Rs2D} !== {5'd3, 5'd0}) begin
         miscompares++;
         $display("FAIL rs_comb: got %0d/%0d expected 3/0", Rs1D, Rs2D);
      end
      rst = 1'b1;
   endtask

   task automatic test_decode_examples();
      set_instr(32'h0050_0093, 32'h100);
      tick();
      vectors++;
      if ({RegWriteE, ALUSrcE, ImmExtE, RdE, ALUControlE, ValidE} !==
          {1'b1, 1'b1, 32'd5, 5'd1, 4'b0000, 1'b1}) begin
         miscompares++;
         $display("FAIL addi: got rw=%b src=%b imm=%h rd=%0d alu=%b v=%b expected 1 1 5 1 0000 1",
                  RegWriteE, ALUSrcE, ImmExtE, RdE, ALUControlE, ValidE);
      end
      set_instr(32'h0001_8233, 32'h104);
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEAD_BEEF;
      tick();
      vectors++;
      if (RD1E !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL write_through: got %h expected deadbeef", RD1E);
      end
      RegWriteW = 1'b0;
      tick();
      vectors++;
      if (RD1E !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL rf_written: got %h expected deadbeef", RD1E);
      end
      set_instr(32'h0000_0233, 32'h108);
      RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234_5678;
      tick();
      vectors++;
      if (RD1E !== 32'd0) begin
         miscompares++;
         $display("FAIL x0_bypass: got %h expected 0", RD1E);
      end
      RegWriteW = 1'b0;
      tick();
      vectors++;
      if (RD1E !== 32'd0) begin
         miscompares++;
         $display("FAIL x0_read: got %h expected 0", RD1E);
      end
      set_instr(32'hFE00_0EE3, 32'h10C);
      tick();
      vectors++;
      if ({BranchE, ImmExtE, ALUControlE, Funct3E} !== {1'b1, 32'hFFFF_FFFC, 4'b0001, 3'b000}) begin
         miscompares++;
         $display("FAIL beq: got br=%b imm=%h alu=%b f3=%b expected 1 fffffffc 0001 000",
                  BranchE, ImmExtE, ALUControlE, Funct3E);
      end
      set_instr(32'h1234_52B7, 32'h110);
      tick();
      vectors++;
      if ({ImmExtE, ALUControlE, RdE} !== {32'h1234_5000, 4'b1010, 5'd5}) begin
         miscompares++;
         $display("FAIL lui: got imm=%h alu=%b rd=%0d expected 12345000 1010 5",
                  ImmExtE, ALUControlE, RdE);
      end
      set_instr(32'hFFFF_FFFF, 32'h114);
      tick();
      vectors++;
      if ({IllegalE, RegWriteE, MemWriteE} !== 3'b100) begin
         miscompares++;
         $display("FAIL illegal: got ill=%b rw=%b mw=%b expected 1 0 0", IllegalE, RegWriteE, MemWriteE);
      end
      ValidD = 1'b0;
      tick();
      vectors++;
      if ({IllegalE, ValidE, RegWriteE} !== 3'b000) begin
         miscompares++;
         $display("FAIL bubble: got ill=%b v=%b rw=%b expected 0 0 0", IllegalE, ValidE, RegWriteE);
      end
   endtask

   task automatic test_stall_flush();
      set_instr(32'h0001_8233, 32'h200);
      tick();
      StallE = 1'b1;
      set_instr(32'h1234_52B7, 32'h204);
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0BAD_F00D;
      for (int c = 0; c < 2; c++) begin
         tick();
         RegWriteW = 1'b0;
         vectors++;
         if ({RD1E, RegWriteE, ALUControlE, RdE, PCE} !== {32'hDEAD_BEEF, 1'b1, 4'b0000, 5'd4, 32'h200}) begin
            miscompares++;
            $display("FAIL stall_hold: got rd1=%h rw=%b alu=%b rd=%0d pc=%h expected deadbeef 1 0000 4 200",
                     RD1E, RegWriteE, ALUControlE, RdE, PCE);
         end
      end
      StallE = 1'b0;
      set_instr(32'h0001_8233, 32'h208);
      tick();
      vectors++;
      if (RD1E !== 32'h0BAD_F00D) begin
         miscompares++;
         $display("FAIL write_during_stall: got %h expected 0badf00d", RD1E);
      end
      StallE = 1'b1; FlushE = 1'b1;
      tick();
      vectors++;
      if (act !== 192'd0) begin
         miscompares++;
         $display("FAIL flush_over_stall: got %h expected 0", act);
      end
      StallE = 1'b0; FlushE = 1'b0;
   endtask

   task automatic test_random();
      logic [6:0] ops [13];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000, 7'b0010111, 7'b1110011, 7'b0001111};
      for (int n = 0; n < 400; n++) begin
         InstrD    = {$urandom()};
         InstrD[6:0] = ops[$urandom_range(0, 12)];
         ValidD    = ($urandom_range(0, 7) != 0);
         PCD       = {$urandom()} & 32'hFFFF_FFFC;
         PCPlus4D  = PCD + 32'd4;
         RegWriteW = $urandom_range(0, 1) == 1;
         RdW       = 5'($urandom_range(0, 31));
         ResultW   = {$urandom()};
         StallE    = ($urandom_range(0, 7) == 0);
         FlushE    = ($urandom_range(0, 9) == 0);
         tick();
         vectors++;
         if ((act & msk_q) !== (exp_q & msk_q)) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h expected %h mask %h", n, act, exp_q, msk_q);
         end
      end
      StallE = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
   endtask

   task automatic test_async_reset();
      set_instr(32'h0050_0093, 32'h300);
      tick();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if (act !== 192'd0) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected 0", act);
      end
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 1; i < 32; i++) begin
         set_instr({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011}, 32'h400);
         tick();
         vectors++;
         if ({RD1E, RD2E} !== 64'd0) begin
            miscompares++;
            $display("FAIL reg_cleared x%0d: got %h/%h expected 0/0", i, RD1E, RD2E);
         end
      end
   endtask

   initial begin
      test_reset();
      test_decode_examples();
      test_stall_flush();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage RV32I pipeline: takes the instruction/PC bundle from the fetch/decode register, decodes control, extends the immediate, reads the register file and registers everything into the ID/EX boundary. It contains the architectural register file, whose write port is driven by the writeback stage. It also provides stall/flush hooks for the hazard unit.

## Interface
- W, 32, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- InstrD  in  W  instruction from fetch/decode register
- PCD, PCPlus4D  in  W  PC and PC+4 of InstrD
- ValidD  in  1  InstrD is a real instruction (0 = bubble)
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  W  writeback data
- StallE  in  1  hold ID/EX register
- FlushE  in  1  turn ID/EX contents into a bubble
- Rs1D, Rs2D  out  5  source indices, combinational, for hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  4  ALU opcode (riscv_pkg::alu_op_t)
- Funct3E  out  3  branch/memory size qualifier
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  W  registered data
- RdE, Rs1E, Rs2E  out  5  registered register indices
- ValidE, IllegalE  out  1  valid bubble flag; unrecognised opcode flag

## Operation
- Supported: R-type ALU, I-type ALU (incl. shifts), lw, sw, beq/bne/blt/bge/bltu/bgeu, jal, jalr, lui.
- Immediate: I, S, B (bit0=0), J (bit0=0), U (low 12 bits 0); all sign-extended from the instruction's bit 31.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001, PASSB 1010 (lui). Branches use SUB; loads/stores/jalr use ADD.
- R-type funct7[5]=1 selects SUB/SRA; I-type uses it only for SRAI.
- Unknown opcode, or ValidD=0: all write/branch/jump controls 0; IllegalE=1 only when ValidD=1 and opcode is unknown.
- Register file: 32×W, x0 reads 0, writes to x0 ignored. Written on rising clk when RegWriteW=1.
- Write-through: if RegWriteW=1, RdW≠0, and RdW equals Rs1D/Rs2D, the read returns ResultW in the same cycle.
- ID/EX update priority: rst → FlushE → StallE → load. Flush clears every E output to 0, including ValidE. Stall holds all E outputs; the register-file write still happens.

## Timing
- Decode-to-E latency: 1 cycle. Rs1D/Rs2D are combinational from InstrD.
- Reset: all E outputs 0, all 32 registers 0; takes effect immediately on rst fall, independent of clk. Reset asserted mid-stream discards the in-flight instruction.
- FlushE and StallE together: the flush wins and a bubble is loaded.
- Writeback to a register read by a stalled instruction: RD1E/RD2E keep the stale captured value. The hazard unit forwards it.

## Structure
- riscv_pkg: opcode constants, alu_op_t, imm_src_t enum (I, S, B, J, U), result_src encodings.
- Sub-module regfile: 2 read, 1 write port, with the write-through logic. Decode logic and immediate extension stay inline in decode_stage.

## Test plan
- Reset, then InstrD=0x00500093 (addi x1,x0,5), ValidD=1 → next edge: RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=0000, ValidE=1.
- Same cycle RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, InstrD=0x00018233 (add x4,x3,x0) → RD1E=0xDEADBEEF. Repeat with RdW=0 → RD1E of a later x0 read is 0.
- InstrD=0xFE000EE3 (beq x0,x0,-4) → BranchE=1, ImmExtE=0xFFFFFFFC, ALUControlE=0001, Funct3E=000.
- InstrD=0x123452B7 (lui x5,0x12345) → ImmExtE=0x12345000, ALUControlE=1010, RdE=5; InstrD=0xFFFFFFFF → IllegalE=1, RegWriteE=0, MemWriteE=0.
- Load addi, then StallE=1 for 2 cycles with new InstrD → E outputs unchanged. Then StallE=1 and FlushE=1 → all E outputs 0.
- rst low asynchronously between edges mid-stream → all E outputs 0 before the next edge; registers x1–x31 read 0.
